// File: rtl/iir_tdf1_multichannel.sv
// iir_tdf1_multichannel: time-multiplexed TDF-I IIR filter with double-buffered coefficients and saturating output
module iir_tdf1_multichannel #(
  parameter int ORDER    = 4,
  parameter int CHANNELS = 3,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 18,
  parameter int ACC_W    = 32,
  parameter int A_FRAC   = 14,
  parameter int B_FRAC   = 14,
  localparam int CH_W    = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int AW      = $clog2(2 * ORDER + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]          in_ch,
  input  logic                     clear,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     coef_commit,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          out_ch
);
  localparam int NC = 2 * ORDER + 1;
  localparam int PW = ACC_W + COEF_W;
  localparam logic [CH_W:0] NCH = (CH_W + 1)'(CHANNELS);
  localparam logic signed [COEF_W-1:0] B_ONE = COEF_W'(1 << B_FRAC);
  localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W - 1){1'b0}}};
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(D_MAX);
  localparam logic signed [ACC_W-1:0] Y_MIN = ACC_W'(D_MIN);

  logic signed [COEF_W-1:0] sh [NC];
  logic signed [COEF_W-1:0] sh_nxt [NC];
  logic signed [COEF_W-1:0] act [NC];
  logic signed [DATA_W-1:0] x;
  logic [CH_W-1:0]          x_ch;
  logic                     s1_valid;
  logic signed [ACC_W-1:0]  rz [CHANNELS][ORDER];
  logic signed [ACC_W-1:0]  lz [CHANNELS][ORDER];
  logic signed [ACC_W-1:0]  r_sel [ORDER+1];
  logic signed [ACC_W-1:0]  l_sel [ORDER+1];
  logic signed [ACC_W-1:0]  rn [ORDER];
  logic signed [ACC_W-1:0]  ln [ORDER];
  logic signed [ACC_W-1:0]  v;
  logic signed [ACC_W-1:0]  y;
  logic signed [DATA_W-1:0] y_sat;

  // Round half up by arithmetic shift, then wrap into the state width.
  function automatic logic signed [ACC_W-1:0] rnd(input logic signed [PW-1:0] p, input int s);
    logic signed [PW-1:0] t;
    t = p + $signed(PW'(1) << (s - 1));
    t = t >>> s;
    return t[ACC_W-1:0];
  endfunction

  // Shadow bank with the pending write folded in, so a same-cycle commit sees it.
  always_comb begin
    sh_nxt = sh;
    for (int j = 0; j < NC; j++)
      if (coef_we && coef_addr == AW'(j)) sh_nxt[j] = coef_wdata;
  end

  // Coefficient banks: shadow takes writes, active updates only on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NC; j++) begin
        sh[j]  <= j == 0 ? B_ONE : '0;
        act[j] <= j == 0 ? B_ONE : '0;
      end
    end else begin
      sh <= sh_nxt;
      if (coef_commit) act <= sh_nxt;
    end
  end

  // Input register; out-of-range channels never become valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      x        <= '0;
      x_ch     <= '0;
    end else begin
      s1_valid <= in_valid && ({1'b0, in_ch} < NCH);
      if (in_valid) begin
        x    <= in_data;
        x_ch <= in_ch;
      end
    end
  end

  // Pick the state set of the channel in stage 2; the extra top slot reads as zero.
  always_comb begin
    for (int k = 0; k <= ORDER; k++) begin
      r_sel[k] = '0;
      l_sel[k] = '0;
    end
    for (int i = 0; i < CHANNELS; i++)
      if (x_ch == CH_W'(i))
        for (int k = 0; k < ORDER; k++) begin
          r_sel[k] = rz[i][k];
          l_sel[k] = lz[i][k];
        end
  end

  // Shared datapath: recursive sum, output sum and next states for the selected channel.
  always_comb begin
    v = r_sel[0] + ACC_W'(x);
    y = l_sel[0] + rnd(PW'(v) * PW'(act[0]), B_FRAC);
    for (int k = 0; k < ORDER; k++) begin
      rn[k] = rnd(-(PW'(v) * PW'(act[ORDER+1+k])), A_FRAC) + r_sel[k+1];
      ln[k] = rnd(PW'(v) * PW'(act[k+1]), B_FRAC) + l_sel[k+1];
    end
    y_sat = y > Y_MAX ? D_MAX : y < Y_MIN ? D_MIN : y[DATA_W-1:0];
  end

  // Channel state update; clear overrides the in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < CHANNELS; i++)
        for (int k = 0; k < ORDER; k++) begin
          rz[i][k] <= '0;
          lz[i][k] <= '0;
        end
    end else if (s1_valid) begin
      for (int i = 0; i < CHANNELS; i++)
        if (x_ch == CH_W'(i)) begin
          rz[i] <= rn;
          lz[i] <= ln;
        end
    end
  end

  // Registered output; data and channel hold while no sample completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= y_sat;
        out_ch   <= x_ch;
      end
    end
  end
endmodule

// File: tb/tb_iir_tdf1_multichannel.sv
// tb_iir_tdf1_multichannel: directed and random checks against a history-sum reference model
module tb_iir_tdf1_multichannel;
  localparam int N  = 4;
  localparam int C  = 3;
  localparam int NC = 2 * N + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic [1:0] in_ch = '0;
  logic clear = 1'b0;
  logic coef_we = 1'b0;
  logic [3:0] coef_addr = '0;
  logic signed [17:0] coef_wdata = '0;
  logic coef_commit = 1'b0;
  logic out_valid;
  logic signed [15:0] out_data;
  logic [1:0] out_ch;

  always #5 clk = ~clk;

  iir_tdf1_multichannel dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ch(in_ch),
    .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch)
  );

  int nchk = 0;
  int nerr = 0;
  string phase = "reset";
  int act [NC];
  int sh [NC];
  int hv [C][N];
  int hbank [C][N][NC];
  bit m_v;
  int m_x, m_ch;
  int e_ov, e_od, e_oc;
  int lpf_ref [20];
  int prev, cur;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s.%s: got %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  function automatic longint rr(input longint p, input int s);
    return (p + (longint'(1) << (s - 1))) >>> s;
  endfunction

  function automatic int sat(input int y);
    return y > 32767 ? 32767 : y < -32768 ? -32768 : y;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NC; j++) begin
      act[j] = j == 0 ? 16384 : 0;
      sh[j]  = act[j];
    end
    for (int c = 0; c < C; c++)
      for (int k = 0; k < N; k++) hv[c][k] = 0;
    m_v = 0; m_x = 0; m_ch = 0;
    e_ov = 0; e_od = 0; e_oc = 0;
  endtask

  // Output is the sum over the last N recursive values, each weighted by the bank live when it was made.
  task automatic model_edge(input bit v, input int ch, input int d, input bit we,
                            input int addr, input int wd, input bit cm, input bit clr);
    longint ra, ya;
    int vv;
    if (m_v) begin
      ra = 0;
      for (int k = 1; k <= N; k++) ra += rr(-longint'(hbank[m_ch][k-1][N+k]) * hv[m_ch][k-1], 14);
      vv = int'(ra + m_x);
      ya = rr(longint'(act[0]) * vv, 14);
      for (int k = 1; k <= N; k++) ya += rr(longint'(hbank[m_ch][k-1][k]) * hv[m_ch][k-1], 14);
      e_od = sat(int'(ya));
      e_oc = m_ch;
      e_ov = 1;
      for (int k = N - 1; k > 0; k--) begin
        hv[m_ch][k]    = hv[m_ch][k-1];
        hbank[m_ch][k] = hbank[m_ch][k-1];
      end
      hv[m_ch][0]    = vv;
      hbank[m_ch][0] = act;
    end else e_ov = 0;
    if (clr)
      for (int c = 0; c < C; c++)
        for (int k = 0; k < N; k++) hv[c][k] = 0;
    if (we && addr < NC) sh[addr] = wd;
    if (cm) act = sh;
    m_v = v && ch < C;
    if (v) begin
      m_x = d;
      m_ch = ch;
    end
  endtask

  task automatic step(input bit v, input int ch, input int d, input bit we,
                      input int addr, input int wd, input bit cm, input bit clr);
    in_valid = v; in_ch = 2'(ch); in_data = 16'(d);
    coef_we = we; coef_addr = 4'(addr); coef_wdata = 18'(wd);
    coef_commit = cm; clear = clr;
    @(posedge clk);
    model_edge(v, ch, d, we, addr, wd, cm, clr);
    #1;
    chk("out_valid", int'(out_valid), e_ov);
    chk("out_data", int'(out_data), e_od);
    chk("out_ch", int'(out_ch), e_oc);
  endtask

  task automatic smp(input int ch, input int d);
    step(1, ch, d, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input bit clr);
    step(0, 0, 0, 0, 0, 0, 0, clr);
  endtask

  task automatic wr(input int addr, input int wd, input bit cm);
    step(0, 0, 0, 1, addr, wd, cm, 0);
  endtask

  task automatic load_lpf();
    wr(0, 2048, 0);
    wr(1, 2048, 0);
    wr(5, -12288, 1);
    idle(1);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_ch", int'(out_ch), 0);
    #11 rst_n = 1'b1;

    phase = "pass";
    smp(0, 1000);
    smp(0, -500);
    chk("first", int'(out_data), 1000);
    smp(0, 0);
    chk("second", int'(out_data), -500);
    idle(0);
    chk("third", int'(out_data), 0);
    idle(0);

    phase = "lpf";
    load_lpf();
    for (int i = 0; i < 60; i++) begin
      smp(0, 8000);
      if (i == 1) chk("first_out", int'(out_data), 1000);
      if (i > 0) begin
        cur = int'(out_data);
        if (i <= 20) lpf_ref[i-1] = e_od;
        if (i > 1) chk("monotonic", int'(cur >= prev), 1);
        prev = cur;
      end
    end
    idle(0);
    chk("converged", int'(out_data >= 7999 && out_data <= 8001), 1);

    phase = "indep";
    idle(1);
    for (int i = 0; i < 20; i++) begin
      smp(1, 8000);
      smp(0, 0);
      chk("ch1_seq", int'(out_data), lpf_ref[i]);
      smp(2, 0);
      chk("ch0_zero", int'(out_data), 0);
    end
    smp(3, 1234);
    idle(0);
    chk("drop", int'(out_valid), 0);

    phase = "sat";
    wr(0, 65536, 0);
    wr(1, 0, 0);
    wr(5, 0, 1);
    idle(1);
    smp(0, 16000);
    smp(0, -16000);
    chk("pos", int'(out_data), 32767);
    idle(0);
    chk("neg", int'(out_data), -32768);
    wr(0, 16384, 1);
    smp(0, 123);
    idle(0);
    chk("state_clean", int'(out_data), 123);

    phase = "commit";
    idle(1);
    smp(0, 4000);
    smp(0, 4000);
    step(1, 0, 4000, 1, 0, 8192, 0, 0);
    smp(0, 4000);
    smp(0, 4000);
    chk("pre", int'(out_data), 4000);
    step(1, 0, 4000, 0, 0, 0, 1, 0);
    chk("commit_edge", int'(out_data), 4000);
    smp(0, 4000);
    chk("post", int'(out_data), 2000);
    smp(0, 4000);
    step(1, 0, 4000, 1, 0, 12000, 1, 0);
    smp(0, 4000);
    smp(0, 4000);
    chk("same_cycle", int'(out_data), 2930);
    wr(12, 5000, 1);
    smp(0, 4000);
    idle(0);
    chk("bad_addr", int'(out_data), 2930);

    phase = "clear";
    wr(0, 2048, 0);
    wr(1, 2048, 0);
    wr(5, -12288, 1);
    for (int i = 0; i < 5; i++) smp(0, 8000);
    step(1, 0, 6000, 0, 0, 0, 0, 1);
    idle(0);
    chk("after_clear", int'(out_data), 750);

    phase = "rst";
    smp(1, 500);
    smp(2, 700);
    #2 rst_n = 1'b0;
    in_valid = 1'b0; coef_we = 1'b0; coef_commit = 1'b0; clear = 1'b0;
    #1;
    model_reset();
    chk("drop_valid", int'(out_valid), 0);
    chk("drop_data", int'(out_data), 0);
    @(posedge clk);
    #1;
    chk("held_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    smp(0, 1000);
    idle(0);
    chk("passthrough", int'(out_data), 1000);

    phase = "rand";
    for (int j = 0; j < NC; j++)
      wr(j, j <= N ? int'($urandom_range(0, 8191)) - 4096 : int'($urandom_range(0, 4095)) - 2048, j == NC - 1);
    idle(1);
    for (int i = 0; i < 400; i++) begin
      int a;
      a = int'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 15) == 0, a,
           a <= N ? int'($urandom_range(0, 8191)) - 4096 : int'($urandom_range(0, 4095)) - 2048,
           $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end
    idle(0);
    idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
